rx_engine_fifo: RTL and testbench
=================================

// Module: rx_engine_fifo
// PURPOSE
//  Parametrised buffer between the rx fetcher side and the rx engine side of the
//  traffic engine. Accepts fetcher words (data/status/error/en/pkt_len), stores them
//  in a DEPTH-word FIFO and forwards them to the engine under engine backpressure.
//  Whole packets that cannot fit are dropped at SOP; drops and overflows are counted.
// PARAMETERS
//  DATA_W     64   data word width, bits; multiple of 8
//  STAT_W     8    status width; carried opaquely except SOP_BIT/EOP_BIT
//  ERR_W      3    error width, carried opaquely
//  LEN_W      16   pkt_len width, bytes
//  DEPTH      512  FIFO words; power of 2, >= 4
//  SOP_BIT    0    status bit index marking first word of packet
//  EOP_BIT    1    status bit index marking last word of packet
//  AF_MARGIN  4    fetch_wr_full asserted when free words < AF_MARGIN
//  CNT_W      32   drop/overflow counter width
// PORTS
//  clk_i            in   1        clock
//  rst_n_i          in   1        synchronous reset, active low
//  fetch_data_i     in   DATA_W   fetcher data word
//  fetch_status_i   in   STAT_W   fetcher status (SOP/EOP)
//  fetch_error_i    in   ERR_W    fetcher error flags
//  fetch_en_i       in   1        fetcher word valid
//  fetch_pkt_len_i  in   LEN_W    packet length, bytes; valid on SOP word
//  fetch_wr_full_o  out  1        backpressure to fetcher
//  eng_data_o       out  DATA_W   engine data word
//  eng_status_o     out  STAT_W   engine status
//  eng_error_o      out  ERR_W    engine error flags
//  eng_en_o         out  1        engine word valid
//  eng_pkt_len_o    out  LEN_W    packet length, forwarded with every word
//  eng_wr_full_i    in   1        engine backpressure
//  drop_cnt_o       out  CNT_W    packets dropped at SOP, saturating
//  ovf_cnt_o        out  CNT_W    words lost to mid-packet overflow, saturating
//  used_o           out  log2(DEPTH)+1  words currently stored
// BEHAVIOUR
//  Reset (rst_n_i low at posedge): pointers, used_o, counters, eng_* outputs -> 0;
//   fetch_wr_full_o -> 0; state -> IDLE. Reset mid-packet discards all FIFO content.
//  Entry FSM, evaluated on fetch_en_i words only:
//   IDLE: word without SOP -> discarded, no count. SOP word: need =
//    ceil(pkt_len/(DATA_W/8)), pkt_len 0 -> need 1. need <= free -> write, go PASS
//    (or stay IDLE if EOP same word). need > free -> discard, drop_cnt++, go DROP
//    (stay IDLE if EOP same word).
//   PASS: write word; FIFO full -> discard word, ovf_cnt++, stay PASS. EOP -> IDLE
//    (EOP word lost to overflow still returns to IDLE). SOP seen in PASS: treated as
//    new packet start, IDLE rules apply same cycle.
//   DROP: discard all words; EOP -> IDLE; SOP -> IDLE rules apply same cycle.
//  free = DEPTH - used_o computed on registered used_o (read in same cycle not credited).
//  fetch_wr_full_o registered: 1 when (DEPTH - used_o) < AF_MARGIN after this cycle's
//   write/read.
//  Read side: read issued when FIFO non-empty and eng_wr_full_i == 0; eng_en_o
//   registered, high cycle after read with that word. Engine tolerates one in-flight
//   word after raising eng_wr_full_i. eng_* data hold last value when eng_en_o low.
//  Latency: word written at cycle N -> eng_en_o at N+2 (empty FIFO, no backpressure).
//   Throughput 1 word/clk each side; simultaneous read+write leaves used_o unchanged.
//  Pointers log2(DEPTH) bits, wrap naturally; used_o saturates at DEPTH never exceeds.
//  Counters saturate at all-ones, never wrap.
// TESTING
//  1 reset: hold rst_n_i=0 3 clk mid-traffic -> all outputs 0, used_o=0, next pkt OK.
//  2 passthrough: 64B pkt (8 words), eng_wr_full_i=0 -> 8 eng_en_o from N+2,
//    data/status/error identical, drop_cnt=0.
//  3 drop: fill to used=510, send 64B pkt (need 8 > free 2) -> pkt absent at output,
//    drop_cnt=1; next 16B pkt after drain passes intact.
//  4 overflow: eng_wr_full_i=1, ignore fetch_wr_full_o, push 520 words in one pkt
//    (pkt_len small) -> used_o=512, ovf_cnt=8, FSM back in IDLE after EOP.
//  5 backpressure: toggle eng_wr_full_i every clk over 1518B pkt -> no loss, no dup,
//    order preserved; fetch_wr_full_o asserted exactly when free < 4.
//  6 wrap/boundary: stream 3*DEPTH words at full rate both sides, 1-word SOP+EOP pkts,
//    pkt_len=0 -> all delivered, counters 0.

Source files
------------

// File: rtl/rx_engine_fifo.sv
// rx_engine_fifo
//   Buffer between the rx fetcher and the rx engine. Fetcher words
//   (data/status/error/pkt_len) go into a DEPTH-word FIFO and come out to the
//   engine under engine backpressure. A packet is admitted at SOP only if all
//   of its words fit; otherwise the whole packet is dropped and counted. Words
//   that hit a full FIFO in the middle of an admitted packet are counted as
//   overflow.
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   fetch_data_i          fetcher data word
//   fetch_status_i        fetcher status (SOP_BIT / EOP_BIT, other bits opaque)
//   fetch_error_i         fetcher error flags (opaque)
//   fetch_en_i            fetcher word valid
//   fetch_pkt_len_i       packet length in bytes, meaningful on the SOP word
//   fetch_wr_full_o       registered almost-full backpressure to the fetcher
//   eng_data_o            engine data word
//   eng_status_o          engine status
//   eng_error_o           engine error flags
//   eng_en_o              engine word valid (registered)
//   eng_pkt_len_o         packet length, forwarded with every word
//   eng_wr_full_i         engine backpressure
//   drop_cnt_o            packets dropped at SOP (saturating)
//   ovf_cnt_o             words lost to mid-packet overflow (saturating)
//   used_o                words currently stored
module rx_engine_fifo #(
  parameter int DATA_W    = 64,
  parameter int STAT_W    = 8,
  parameter int ERR_W     = 3,
  parameter int LEN_W     = 16,
  parameter int DEPTH     = 512,
  parameter int SOP_BIT   = 0,
  parameter int EOP_BIT   = 1,
  parameter int AF_MARGIN = 4,
  parameter int CNT_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [DATA_W-1:0]          fetch_data_i,
  input  logic [STAT_W-1:0]          fetch_status_i,
  input  logic [ERR_W-1:0]           fetch_error_i,
  input  logic                       fetch_en_i,
  input  logic [LEN_W-1:0]           fetch_pkt_len_i,
  output logic                       fetch_wr_full_o,
  output logic [DATA_W-1:0]          eng_data_o,
  output logic [STAT_W-1:0]          eng_status_o,
  output logic [ERR_W-1:0]           eng_error_o,
  output logic                       eng_en_o,
  output logic [LEN_W-1:0]           eng_pkt_len_o,
  input  logic                       eng_wr_full_i,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic [CNT_W-1:0]           ovf_cnt_o,
  output logic [$clog2(DEPTH):0]     used_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int BYTES = DATA_W / 8;
  // Common width for comparing the word count a packet needs against free space.
  localparam int CW    = ((LEN_W > AW) ? LEN_W : AW) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STAT_W-1:0] status;
    logic [ERR_W-1:0]  error;
    logic [LEN_W-1:0]  pkt_len;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     used;
  logic [AW:0]     used_nxt;
  logic [AW:0]     free_now;
  logic [AW:0]     free_nxt;
  logic [LEN_W:0]  need_raw;
  logic [CW-1:0]   need_c;
  logic [CW-1:0]   free_c;
  logic            is_sop;
  logic            is_eop;
  logic            fifo_full;
  logic            wr_en;
  logic            rd_en;
  logic            drop_inc;
  logic            ovf_inc;
  state_t          state;
  state_t          state_nxt;

  assign wr_entry  = '{data: fetch_data_i, status: fetch_status_i,
                       error: fetch_error_i, pkt_len: fetch_pkt_len_i};
  assign is_sop    = fetch_status_i[SOP_BIT];
  assign is_eop    = fetch_status_i[EOP_BIT];

  // Free space is judged on the registered fill level only; a read in the
  // same cycle does not make room for this cycle's write.
  assign free_now  = (AW+1)'(DEPTH) - used;
  assign fifo_full = (used == (AW+1)'(DEPTH));

  // Words needed for the packet: ceil(len / bytes-per-word), a zero length
  // still occupies one word.
  assign need_raw  = ({1'b0, fetch_pkt_len_i} + (LEN_W+1)'(BYTES - 1)) / (LEN_W+1)'(BYTES);
  assign need_c    = (need_raw == '0) ? CW'(1) : CW'(need_raw);
  assign free_c    = CW'(free_now);

  assign rd_en     = (used != '0) && !eng_wr_full_i;
  assign used_nxt  = used + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  assign free_nxt  = (AW+1)'(DEPTH) - used_nxt;

  // Entry decision. An SOP always restarts admission regardless of the
  // current state, so PASS and DROP both fall into the same SOP rule.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wr_en     = 1'b0;
    drop_inc  = 1'b0;
    ovf_inc   = 1'b0;
    state_nxt = state;
    if (fetch_en_i) begin
      if (is_sop) begin
        if (need_c <= free_c) begin
          wr_en     = 1'b1;
          state_nxt = is_eop ? IDLE : PASS;
        end else begin
          drop_inc  = 1'b1;
          state_nxt = is_eop ? IDLE : DROP;
        end
      end else begin
        case (state)
          PASS: begin
            if (fifo_full) ovf_inc = 1'b1;
            else           wr_en   = 1'b1;
            if (is_eop) state_nxt = IDLE;
          end
          DROP: begin
            if (is_eop) state_nxt = IDLE;
          end
          default: ; // IDLE: stray non-SOP word is discarded silently
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are meaningless until
  // written, and the pointers/used count decide what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      used            <= '0;
      state           <= IDLE;
      fetch_wr_full_o <= 1'b0;
      eng_en_o        <= 1'b0;
      eng_data_o      <= '0;
      eng_status_o    <= '0;
      eng_error_o     <= '0;
      eng_pkt_len_o   <= '0;
      drop_cnt_o      <= '0;
      ovf_cnt_o       <= '0;
    end else begin
      state           <= state_nxt;
      used            <= used_nxt;
      fetch_wr_full_o <= (free_nxt < (AW+1)'(AF_MARGIN));
      eng_en_o        <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr        <= rd_ptr + 1'b1;
        eng_data_o    <= mem[rd_ptr].data;
        eng_status_o  <= mem[rd_ptr].status;
        eng_error_o   <= mem[rd_ptr].error;
        eng_pkt_len_o <= mem[rd_ptr].pkt_len;
      end
      if (drop_inc && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
      if (ovf_inc  && !(&ovf_cnt_o))  ovf_cnt_o  <= ovf_cnt_o + 1'b1;
    end
  end

  assign used_o = used;

endmodule

// File: tb/tb_rx_engine_fifo.sv
// Self-checking bench for rx_engine_fifo. A queue-based reference model is
// updated at every rising edge from the same inputs the DUT sees; all DUT
// outputs are compared against it 1 ns after each edge.
module tb_rx_engine_fifo;

  localparam int DATA_W    = 64;
  localparam int STAT_W    = 8;
  localparam int ERR_W     = 3;
  localparam int LEN_W     = 16;
  localparam int DEPTH     = 512;
  localparam int SOP_BIT   = 0;
  localparam int EOP_BIT   = 1;
  localparam int AF_MARGIN = 4;
  localparam int CNT_W     = 32;
  localparam int BYTES     = DATA_W / 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [DATA_W-1:0]       fetch_data;
  logic [STAT_W-1:0]       fetch_status;
  logic [ERR_W-1:0]        fetch_error;
  logic                    fetch_en;
  logic [LEN_W-1:0]        fetch_pkt_len;
  logic                    fetch_wr_full;
  logic [DATA_W-1:0]       eng_data;
  logic [STAT_W-1:0]       eng_status;
  logic [ERR_W-1:0]        eng_error;
  logic                    eng_en;
  logic [LEN_W-1:0]        eng_pkt_len;
  logic                    eng_wr_full;
  logic [CNT_W-1:0]        drop_cnt;
  logic [CNT_W-1:0]        ovf_cnt;
  logic [$clog2(DEPTH):0]  used;

  rx_engine_fifo #(
    .DATA_W(DATA_W), .STAT_W(STAT_W), .ERR_W(ERR_W), .LEN_W(LEN_W),
    .DEPTH(DEPTH), .SOP_BIT(SOP_BIT), .EOP_BIT(EOP_BIT),
    .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .fetch_data_i(fetch_data), .fetch_status_i(fetch_status),
    .fetch_error_i(fetch_error), .fetch_en_i(fetch_en),
    .fetch_pkt_len_i(fetch_pkt_len), .fetch_wr_full_o(fetch_wr_full),
    .eng_data_o(eng_data), .eng_status_o(eng_status),
    .eng_error_o(eng_error), .eng_en_o(eng_en),
    .eng_pkt_len_o(eng_pkt_len), .eng_wr_full_i(eng_wr_full),
    .drop_cnt_o(drop_cnt), .ovf_cnt_o(ovf_cnt), .used_o(used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [STAT_W-1:0] s;
    logic [ERR_W-1:0]  e;
    logic [LEN_W-1:0]  l;
  } word_t;

  // Reference model: queue contents, last delivered word, counters and the
  // packet-admission mode (0 = between packets, 1 = keeping, 2 = discarding).
  word_t q[$];
  word_t exp_out;
  bit    exp_en;
  bit    exp_af;
  int    exp_drop;
  int    exp_ovf;
  int    mode;

  int total = 0;
  int bad   = 0;
  int bp_mode = 0;  // 0 ready, 1 stalled, 2 toggle, 3 random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int    sz;
    bit    rd;
    bit    push;
    int    need;
    word_t w;
    if (!rst_n) begin
      q.delete();
      exp_en   = 1'b0;
      exp_out  = '{d: '0, s: '0, e: '0, l: '0};
      exp_drop = 0;
      exp_ovf  = 0;
      mode     = 0;
      exp_af   = 1'b0;
      return;
    end
    sz   = q.size();
    rd   = (sz > 0) && !eng_wr_full;
    push = 1'b0;
    w    = '{d: fetch_data, s: fetch_status, e: fetch_error, l: fetch_pkt_len};
    if (fetch_en) begin
      if (fetch_status[SOP_BIT]) begin
        need = (int'(fetch_pkt_len) + BYTES - 1) / BYTES;
        if (need == 0) need = 1;
        if (need <= DEPTH - sz) begin
          push = 1'b1;
          mode = fetch_status[EOP_BIT] ? 0 : 1;
        end else begin
          exp_drop++;
          mode = fetch_status[EOP_BIT] ? 0 : 2;
        end
      end else if (mode == 1) begin
        if (sz == DEPTH) exp_ovf++;
        else             push = 1'b1;
        if (fetch_status[EOP_BIT]) mode = 0;
      end else if (mode == 2) begin
        if (fetch_status[EOP_BIT]) mode = 0;
      end
    end
    if (rd) begin
      exp_out = q.pop_front();
      exp_en  = 1'b1;
    end else begin
      exp_en  = 1'b0;
    end
    if (push) q.push_back(w);
    exp_af = (DEPTH - q.size()) < AF_MARGIN;
  endtask

  task automatic compare_all();
    check("eng_en",     64'(eng_en),      64'(exp_en));
    check("eng_data",   64'(eng_data),    64'(exp_out.d));
    check("eng_status", 64'(eng_status),  64'(exp_out.s));
    check("eng_error",  64'(eng_error),   64'(exp_out.e));
    check("eng_len",    64'(eng_pkt_len), 64'(exp_out.l));
    check("used",       64'(used),        64'(q.size()));
    check("wr_full",    64'(fetch_wr_full), 64'(exp_af));
    check("drop_cnt",   64'(drop_cnt),    64'(exp_drop));
    check("ovf_cnt",    64'(ovf_cnt),     64'(exp_ovf));
  endtask

  // One clock: apply backpressure pattern, let the edge happen, update the
  // model from the inputs seen at that edge, then compare.
  task automatic step();
    case (bp_mode)
      0:       eng_wr_full = 1'b0;
      1:       eng_wr_full = 1'b1;
      2:       eng_wr_full = ~eng_wr_full;
      default: eng_wr_full = 1'($urandom);
    endcase
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    fetch_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    bp_mode = 0;
    idle(q.size() + 3);
  endtask

  task automatic drive_word(input bit sop, input bit eop, input int len);
    logic [STAT_W-1:0] s;
    s = STAT_W'($urandom);
    s[SOP_BIT] = sop;
    s[EOP_BIT] = eop;
    fetch_en      = 1'b1;
    fetch_data    = {$urandom, $urandom};
    fetch_status  = s;
    fetch_error   = ERR_W'($urandom);
    fetch_pkt_len = LEN_W'(len);
  endtask

  // Sends nwords words of one packet; with honor_af it waits (bounded) while
  // fetch_wr_full is high, as a well-behaved fetcher would.
  task automatic send_pkt(input int len, input int nwords, input bit honor_af);
    int waited;
    for (int i = 0; i < nwords; i++) begin
      if (honor_af) begin
        waited = 0;
        fetch_en = 1'b0;
        while (fetch_wr_full && waited < 1000) begin
          step();
          waited++;
        end
        if (waited >= 1000) check("af_timeout", 64'(fetch_wr_full), 64'd0);
      end
      drive_word(i == 0, i == nwords - 1, len);
      step();
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    int len;
    int nw;
    rst_n         = 1'b0;
    fetch_en      = 1'b0;
    fetch_data    = '0;
    fetch_status  = '0;
    fetch_error   = '0;
    fetch_pkt_len = '0;
    eng_wr_full   = 1'b0;
    bp_mode       = 0;
    repeat (3) step();
    rst_n = 1'b1;

    // Passthrough: one 64-byte packet, engine always ready.
    send_pkt(64, 8, 1'b0);
    idle(6);
    check("t2_drop_zero", 64'(drop_cnt), 64'd0);

    // Reset in the middle of a packet with words queued.
    bp_mode = 1;
    drive_word(1'b1, 1'b0, 64);
    step();
    for (int i = 0; i < 4; i++) begin
      drive_word(1'b0, 1'b0, 64);
      step();
    end
    rst_n = 1'b0;
    repeat (3) step();
    check("t1_used_rst", 64'(used), 64'd0);
    check("t1_en_rst",   64'(eng_en), 64'd0);
    rst_n = 1'b1;
    send_pkt(16, 2, 1'b0);
    drain();

    // Drop: fill to 510 words, then a packet that needs 8 with only 2 free.
    bp_mode = 1;
    send_pkt(8, 510, 1'b0);
    check("t3_used_510", 64'(used), 64'd510);
    send_pkt(64, 8, 1'b0);
    check("t3_drop_one", 64'(drop_cnt), 64'd1);
    check("t3_used_keep", 64'(used), 64'd510);
    drain();
    send_pkt(16, 2, 1'b0);
    idle(5);

    // Overflow: 520 words of one admitted packet into a stalled FIFO.
    bp_mode = 1;
    send_pkt(8, 520, 1'b0);
    check("t4_used_full", 64'(used), 64'(DEPTH));
    check("t4_ovf_8", 64'(ovf_cnt), 64'd8);
    // Back in IDLE: a stray non-SOP word must not count as overflow.
    drive_word(1'b0, 1'b0, 8);
    step();
    fetch_en = 1'b0;
    check("t4_ovf_idle", 64'(ovf_cnt), 64'd8);
    drain();

    // Backpressure toggling every clock over a 1518-byte packet.
    bp_mode = 2;
    send_pkt(1518, (1518 + BYTES - 1) / BYTES, 1'b1);
    idle(8);
    drain();

    // Wrap: 3*DEPTH single-word packets with zero length at full rate.
    bp_mode = 0;
    for (int i = 0; i < 3 * DEPTH; i++) send_pkt(0, 1, 1'b0);
    idle(4);
    check("t6_drop_same", 64'(drop_cnt), 64'd1);
    check("t6_ovf_same",  64'(ovf_cnt),  64'd8);
    check("t6_used_zero", 64'(used),     64'd0);

    // Random packets, random gaps, random engine backpressure.
    bp_mode = 3;
    for (int p = 0; p < 60; p++) begin
      len = int'($urandom_range(0, 400));
      nw  = (len + BYTES - 1) / BYTES;
      if (nw == 0) nw = 1;
      if ($urandom_range(0, 7) == 0) begin
        drive_word(1'b0, 1'b0, len);
        step();
      end
      send_pkt(len, nw, ($urandom_range(0, 3) != 0));
      idle(int'($urandom_range(0, 3)));
    end
    drain();
    check("end_used_zero", 64'(used), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
